// File: rtl/adder_measure_pkg.sv
// rtl/adder_measure_pkg.sv - shared types and constants for the adder delay measurement controller
package adder_measure_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_CNT_W         = 32;
    localparam int DEF_GATE_W        = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_SYNC_STAGES   = 2;

    // DRAIN lasts one cycle longer than the synchroniser so the last edge
    // seen at chain_out before ring_en drops still reaches the counter.
    function automatic int drain_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/edge_sync_counter.sv
// rtl/edge_sync_counter.sv - chain_out synchroniser, rising-edge detect and saturating counter
module edge_sync_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             async_in,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    logic                   rise;

    // Shift the asynchronous input through the synchroniser and keep one extra
    // delayed copy of its output for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            sync_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], async_in};
            sync_q <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sync_q;

    // Count enabled rising edges; an edge arriving while the count is already
    // all-ones is lost, so that is the moment overflow is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (en && rise) begin
            if (count == '1) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adder_measure_ctrl.sv
// rtl/adder_measure_ctrl.sv - sequences one settle/capture/ring-count measurement on the adder
module adder_measure_ctrl
    import adder_measure_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ack,
    input  logic              chain_out,
    input  logic [WIDTH-1:0]  s_output,
    output logic [WIDTH-1:0]  a_input,
    output logic [WIDTH-1:0]  b_input,
    output logic              ring_en,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  sum,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int DRAIN_CYCLES = drain_cycles(SYNC_STAGES);
    localparam int TMR_W        = (GATE_W > 8) ? GATE_W : 8;

    state_t              state;
    logic                start_q;
    logic [GATE_W-1:0]   gate_r;
    logic [TMR_W-1:0]    timer;
    logic                start_edge;
    logic                accept;
    logic                cnt_en;

    assign start_edge = start & ~start_q;
    // A new measurement is only taken when idle or holding a result, and abort has priority.
    assign accept     = start_edge && !abort && (state == ST_IDLE || state == ST_DONE);
    assign cnt_en     = (state == ST_RUN) || (state == ST_DRAIN);

    // Measurement sequencer with registered ring_en/busy/done so ring_en cannot glitch.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            gate_r  <= '0;
            timer   <= '0;
            a_input <= '0;
            b_input <= '0;
            sum     <= '0;
            ring_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            if (abort) begin
                state   <= ST_IDLE;
                ring_en <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (accept) begin
                            a_input <= op_a;
                            b_input <= op_b;
                            gate_r  <= gate_len;
                            sum     <= '0;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                            state   <= ST_LOAD;
                        end else if (state == ST_DONE && ack) begin
                            done  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_LOAD: begin
                        timer <= TMR_W'(SETTLE_CYCLES - 1);
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (timer == '0) begin
                            sum <= s_output;
                            if (gate_r != '0) begin
                                ring_en <= 1'b1;
                                timer   <= TMR_W'(gate_r) - TMR_W'(1);
                                state   <= ST_RUN;
                            end else begin
                                timer <= TMR_W'(DRAIN_CYCLES - 1);
                                state <= ST_DRAIN;
                            end
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (timer == '0) begin
                            ring_en <= 1'b0;
                            timer   <= TMR_W'(DRAIN_CYCLES - 1);
                            state   <= ST_DRAIN;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (timer == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    default: begin
                        ring_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    edge_sync_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_counter (
        .clk      (wb_clk_i),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .clr      (accept),
        .async_in (chain_out),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// tb/tb_adder_measure_ctrl.sv - self-checking bench for adder_measure_ctrl
module tb_adder_measure_ctrl;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 4;
    localparam int GATE_W = 16;
    localparam int SETTLE = 4;
    localparam int SYNC   = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              ack = 1'b0;
    logic              chain_out = 1'b0;
    logic [WIDTH-1:0]  op_a = '0;
    logic [WIDTH-1:0]  op_b = '0;
    logic [GATE_W-1:0] gate_len = '0;
    logic [WIDTH-1:0]  s_output;
    logic [WIDTH-1:0]  a_input;
    logic [WIDTH-1:0]  b_input;
    logic [WIDTH-1:0]  sum;
    logic              ring_en;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Behavioural adder core.
    assign s_output = a_input + b_input;

    adder_measure_ctrl #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .GATE_W(GATE_W),
        .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
    ) dut (
        .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .gate_len(gate_len), .ack(ack),
        .chain_out(chain_out), .s_output(s_output), .a_input(a_input),
        .b_input(b_input), .ring_en(ring_en), .busy(busy), .done(done),
        .sum(sum), .count(count), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: timeline of one measurement ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
    mmode_t           mmode = M_IDLE;
    int               cyc = 0;
    int               t0 = 0;
    int               g = 0;
    logic             start_prev = 1'b0;
    logic             chist [0:4095];
    logic [WIDTH-1:0] m_sum = '0;
    int               m_cnt = 0;
    logic             m_ovf = 1'b0;
    logic             res_known = 1'b1;

    // Timeline from the start edge t0 (k = edges since t0):
    //   k=0 load, k=1..SETTLE settle, then gate cycles of ring_en, then SYNC+1 drain,
    //   done from k = SETTLE+g+SYNC+2. chain samples whose rising transition lands at
    //   edge n in [t0+SETTLE+2-SYNC, t0+SETTLE+g+2] are the ones the counter sees.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmode      = M_IDLE;
            start_prev = 1'b0;
            m_sum      = '0;
            m_cnt      = 0;
            m_ovf      = 1'b0;
            res_known  = 1'b1;
        end else begin
            cyc++;
            chist[cyc % 4096] = chain_out;
            if (abort) begin
                if (mmode == M_RUN) res_known = 1'b0;
                mmode = M_IDLE;
            end else if (mmode == M_RUN) begin
                if (cyc - t0 == SETTLE + g + SYNC + 2) begin
                    int r;
                    r = 0;
                    for (int n = t0 + SETTLE + 2 - SYNC; n <= t0 + SETTLE + g + 2; n++)
                        if (chist[n % 4096] && !chist[(n - 1) % 4096]) r++;
                    m_ovf = (r > CMAX);
                    m_cnt = m_ovf ? CMAX : r;
                    mmode = M_DONE;
                end
            end else if (start && !start_prev) begin
                t0        = cyc;
                g         = int'(gate_len);
                m_sum     = op_a + op_b;
                res_known = 1'b1;
                mmode     = M_RUN;
            end else if (mmode == M_DONE && ack) begin
                mmode = M_IDLE;
            end
            start_prev = start;
        end
    end

    // Per-cycle compare against the model, half a period after the active edge.
    always @(negedge clk) begin
        int k;
        if (rst_n) begin
            k = cyc - t0;
            chk("busy", 64'(busy), 64'(mmode == M_RUN));
            chk("ring_en", 64'(ring_en), 64'(mmode == M_RUN && k >= SETTLE + 1 && k <= SETTLE + g));
            chk("done", 64'(done), 64'(mmode == M_DONE));
            if (mmode == M_DONE && res_known) begin
                chk("sum", 64'(sum), 64'(m_sum));
                chk("count", 64'(count), 64'(m_cnt));
                chk("overflow", 64'(overflow), 64'(m_ovf));
            end
        end
    end

    int ring_cnt = 0;
    always @(negedge clk) if (ring_en) ring_cnt++;

    // ---------------- stimulus ----------------
    int cmode = 0;
    int ph = 0;
    int ring_base = 0;
    int ring_len = 0;
    int lat = 0;

    function automatic logic chain_val(input int p);
        case (cmode)
            1:       return (p % 8) >= 4;
            2:       return (p % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        ph++;
        chain_out = chain_val(ph);
    endtask

    task automatic run_meas(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int gl,
                            input logic with_ack, input logic busy_pulse, output int l);
        step();
        ph = 0;
        chain_out = chain_val(0);
        op_a = a;
        op_b = b;
        gate_len = GATE_W'(gl);
        start = 1'b1;
        ack = with_ack;
        ring_base = ring_cnt;
        l = 0;
        while (l < 300) begin
            step();
            l++;
            if (l == 1) begin
                start = 1'b0;
                if (with_ack) chk("ack_and_start_done_low", 64'(done), 64'd0);
                ack = 1'b0;
            end
            if (busy_pulse && l == 4) start = 1'b1;
            if (busy_pulse && l == 5) start = 1'b0;
            if (done) break;
        end
        chk("done_reached", 64'(done), 64'd1);
        ring_len = ring_cnt - ring_base;
    endtask

    initial begin
        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ring", 64'(ring_en), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_a", 64'(a_input), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // 1: zero gate
        cmode = 0;
        run_meas(32'd5, 32'd7, 0, 1'b0, 1'b0, lat);
        chk("t1_latency", 64'(lat), 64'd9);
        chk("t1_sum", 64'(sum), 64'd12);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_ring_cycles", 64'(ring_len), 64'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        chk("t1_done_after_ack", 64'(done), 64'd0);

        // 2: chain period 8, gate 10
        cmode = 1;
        run_meas(32'd100, 32'd23, 10, 1'b0, 1'b0, lat);
        chk("t2_latency", 64'(lat), 64'd19);
        chk("t2_ring_cycles", 64'(ring_len), 64'd10);
        chk("t2_count", 64'(count), 64'd2);
        chk("t2_overflow", 64'(overflow), 64'd0);
        chk("t2_sum", 64'(sum), 64'd123);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 3: saturation
        cmode = 2;
        run_meas(32'hFFFF_FFFF, 32'd1, 40, 1'b0, 1'b0, lat);
        chk("t3_latency", 64'(lat), 64'd49);
        chk("t3_count", 64'(count), 64'd15);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_sum", 64'(sum), 64'd0);

        // 5: ack + start together in DONE, and a start pulse while busy
        run_meas(32'd3, 32'd4, 2, 1'b1, 1'b1, lat);
        chk("t5_latency", 64'(lat), 64'd11);
        chk("t5_sum", 64'(sum), 64'd7);
        chk("t5_count", 64'(count), 64'd2);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 4: abort in the third RUN cycle
        cmode = 0;
        step();
        op_a = 32'd1; op_b = 32'd1; gate_len = GATE_W'(10); start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !ring_en; i++) step();
        chk("t4_ring_seen", 64'(ring_en), 64'd1);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abort_ring", 64'(ring_en), 64'd0);
        chk("t4_abort_busy", 64'(busy), 64'd0);
        chk("t4_abort_done", 64'(done), 64'd0);
        step();
        run_meas(32'd9, 32'd9, 1, 1'b0, 1'b0, lat);
        chk("t4_rerun_latency", 64'(lat), 64'd10);
        chk("t4_rerun_sum", 64'(sum), 64'd18);

        // 6: asynchronous reset mid-RUN
        cmode = 1;
        step();
        op_a = 32'd40; op_b = 32'd2; gate_len = GATE_W'(20); start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !ring_en; i++) step();
        chk("t6_ring_seen", 64'(ring_en), 64'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ring", 64'(ring_en), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_sum", 64'(sum), 64'd0);
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_overflow", 64'(overflow), 64'd0);
        chk("t6_rst_a", 64'(a_input), 64'd0);
        chk("t6_rst_b", 64'(b_input), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("t6_idle_busy", 64'(busy), 64'd0);
        chk("t6_idle_ring", 64'(ring_en), 64'd0);
        cmode = 0;
        run_meas(32'd1, 32'd2, 0, 1'b0, 1'b0, lat);
        chk("t6_rerun_latency", 64'(lat), 64'd9);
        chk("t6_rerun_sum", 64'(sum), 64'd3);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
